sync_test_sequencer: RTL and testbench
======================================

SYNC_TEST_SEQUENCER -- requirements
Module: sync_test_sequencer

Interface
REQ-001 SHALL have parameter W, default 8: data word width.
REQ-002 SHALL have parameter N_WORDS, default 4: words launched per run, 1..15.
REQ-003 SHALL have parameter TIMEOUT, default 63: maximum WAIT cycles per word, 1..255.
REQ-004 clk  in  1  single clock; all flops rise on posedge clk.
REQ-005 rst_n  in  1  synchronous reset, active-high; the name is kept for codebase consistency.
REQ-006 start  in  1  begin a run; sampled only in IDLE.
REQ-007 abort  in  1  terminate a run, effective in any state.
REQ-008 path  in  3  synchronizer path under test; 000..101 valid, same encoding as the datapath mux select.
REQ-009 seed  in  W  pattern seed, captured on an accepted start.
REQ-010 obs_in  in  W  datapath mux output, asynchronous to clk.
REQ-011 sel  out  3  mux select for the datapath.
REQ-012 data_out  out  W  word driven to the datapath input register.
REQ-013 stb  out  1  one-cycle strobe for the pulse synchronizer.
REQ-014 pulse  out  1  one-cycle pulse for the toggle synchronizer.
REQ-015 ena_blocks  out  1  datapath enable.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle run-complete pulse.
REQ-018 pass  out  1  run result; valid from done until the next accepted start.
REQ-019 err_cnt  out  4  saturating count of failed words.
REQ-020 max_lat  out  8  largest per-word latency in the run.

Function
REQ-021 obs_in SHALL pass through a 2-flop synchronizer into obs_s; all comparisons SHALL use obs_s.
REQ-022 The FSM SHALL have exactly these states: IDLE, SETUP, LAUNCH, WAIT, CHECK, DONE.
REQ-023 IDLE -> SETUP: start=1 SHALL capture path and seed, clear err_cnt and max_lat, and load a word counter with N_WORDS.
REQ-024 If the captured path is 110 or 111, IDLE SHALL go directly to DONE with err_cnt=15 and pass=0.
REQ-025 SETUP SHALL drive data_out to the next pattern word.
- If that word equals obs_s, SETUP SHALL advance the pattern once more and stay one extra cycle, so every launched word differs from the current observation.
REQ-026 sel SHALL equal the captured path from SETUP through CHECK; ena_blocks SHALL be 1 from SETUP through CHECK.
REQ-027 LAUNCH SHALL last one cycle and clear the wait timer.
- stb=1 in LAUNCH only when path=011.
- pulse=1 in LAUNCH only when path=100 or 101.
REQ-028 WAIT SHALL increment the timer each cycle and go to CHECK on the first match.
- Match for paths 000..100: obs_s == data_out.
- Match for path 101: obs_s[0] == 1.
REQ-029 WAIT SHALL also go to CHECK when the timer reaches TIMEOUT without a match, flagged as a timeout.
REQ-030 CHECK SHALL last one cycle.
- On a match, per-word latency = timer value; max_lat SHALL update if larger.
- On a timeout, err_cnt SHALL increment, saturating at 15, and max_lat is unchanged.
- Then decrement the word counter: nonzero -> SETUP, zero -> DONE.
REQ-031 DONE SHALL last one cycle: done=1, pass=(err_cnt==0), then IDLE.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 If abort=1 in any non-IDLE state, the FSM SHALL go to IDLE the next cycle.
- done SHALL not pulse.
- sel, data_out, stb, pulse and ena_blocks SHALL go to 0.
- err_cnt and max_lat SHALL hold.
REQ-034 If start and abort are both 1 in IDLE, abort SHALL win and start is dropped.
REQ-035 In IDLE: sel=0, stb=0, pulse=0, ena_blocks=0; data_out holds its last value.

Reset
REQ-036 rst_n=1 at a clock edge SHALL force IDLE and the following, overriding start and abort.
- sel, data_out, stb, pulse, ena_blocks, busy, done, pass, err_cnt and max_lat = 0.
- Both synchronizer flops = 0; pattern register = 0.
REQ-037 Reset asserted mid-run SHALL abandon the run without a done pulse.

Configuration
REQ-038 Macro SYNC_SEQ_LFSR_EN SHALL select the pattern generator.
- Defined: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shift-left, loaded from seed; seed 0 SHALL be replaced by 8'h01.
- Undefined: incrementing counter starting at seed+1, wrapping 8'hFF -> 8'h00.

Verification
REQ-039 Reset during WAIT -> next cycle busy=0, done=0, all outputs 0, no done pulse afterwards.
REQ-040 Counter build, path=000, seed=8'h10, obs_in looped from data_out through one flop -> words 11,12,13,14; each latency 3; done with pass=1, err_cnt=0, max_lat=3.
REQ-041 path=011, obs_in held at 8'h00 -> stb high one cycle per word, four timeouts after 63 WAIT cycles each, err_cnt=4, pass=0.
REQ-042 path=101, obs_in[0] raised 5 cycles after each pulse -> max_lat=7, pass=1.
REQ-043 path=110 -> done 2 cycles after start, err_cnt=15, pass=0, stb and pulse never asserted.
REQ-044 LFSR build, seed=8'h00 -> first word 8'h02; abort on 3rd word -> IDLE next cycle, no done pulse, err_cnt held.

Source files
------------

// File: rtl/sync_test_sequencer.sv
// Synchronizer test sequencer: launches pattern words into a CDC datapath and times their return.
// Define SYNC_SEQ_LFSR_EN for an 8-bit LFSR pattern; otherwise an incrementing counter is used.
module sync_test_sequencer #(
  parameter int W       = 8,
  parameter int N_WORDS = 4,
  parameter int TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [2:0]   path,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] obs_in,
  output logic [2:0]   sel,
  output logic [W-1:0] data_out,
  output logic         stb,
  output logic         pulse,
  output logic         ena_blocks,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [3:0]   err_cnt,
  output logic [7:0]   max_lat
);

  typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT, CHECK, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] sync1_q, obs_s_q, pat_q, pat_d, data_q, data_d, nxt, seed_ld;
  logic [2:0]   path_q, path_d, sel_q, sel_d;
  logic [3:0]   wcnt_q, wcnt_d, err_q, err_d;
  logic [7:0]   timer_q, timer_d, max_q, max_d;
  logic         hit_q, hit_d, stb_q, stb_d, pulse_q, pulse_d, ena_q, ena_d;
  logic         busy_q, busy_d, done_q, done_d, pass_q, pass_d, match, run;

  function automatic logic [W-1:0] next_pat(input logic [W-1:0] p);
`ifdef SYNC_SEQ_LFSR_EN
    return W'({p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]});
`else
    return p + W'(1);
`endif
  endfunction

`ifdef SYNC_SEQ_LFSR_EN
  assign seed_ld = (seed[7:0] == 8'h00) ? W'(8'h01) : W'(seed[7:0]);
`else
  assign seed_ld = seed;
`endif

  // path 101 watches a single returned bit; all other paths expect the full word back
  assign match = (path_q == 3'b101) ? obs_s_q[0] : (obs_s_q == data_q);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    data_d  = data_q;
    path_d  = path_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    timer_d = timer_q;
    max_d   = max_q;
    hit_d   = hit_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    nxt     = next_pat(pat_q);
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      data_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (start && !abort) begin
          path_d = path;
          pat_d  = seed_ld;
          err_d  = 4'd0;
          max_d  = 8'd0;
          wcnt_d = 4'(N_WORDS);
          pass_d = 1'b0;
          if (path[2:1] == 2'b11) begin
            err_d   = 4'hF;
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end
        SETUP: begin
          pat_d  = nxt;
          data_d = nxt;
          if (nxt != obs_s_q) state_d = LAUNCH;
        end
        LAUNCH: begin
          timer_d = 8'd0;
          state_d = WAIT;
        end
        WAIT: begin
          timer_d = timer_q + 8'd1;
          if (match) begin
            hit_d   = 1'b1;
            state_d = CHECK;
          end else if (timer_d == 8'(TIMEOUT)) begin
            hit_d   = 1'b0;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (hit_q) begin
            if (timer_q > max_q) max_d = timer_q;
          end else if (err_q != 4'hF) begin
            err_d = err_q + 4'd1;
          end
          wcnt_d  = wcnt_q - 4'd1;
          state_d = (wcnt_d == 4'd0) ? DONE : SETUP;
        end
        DONE: begin
          done_d  = 1'b1;
          pass_d  = (err_q == 4'd0);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // outputs are registered from the next state so they line up with it
    run     = (state_d == SETUP) || (state_d == LAUNCH) || (state_d == WAIT) || (state_d == CHECK);
    sel_d   = run ? path_d : 3'b000;
    ena_d   = run;
    stb_d   = (state_d == LAUNCH) && (path_d == 3'b011);
    pulse_d = (state_d == LAUNCH) && ((path_d == 3'b100) || (path_d == 3'b101));
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      obs_s_q <= '0;
      pat_q   <= '0;
      data_q  <= '0;
      path_q  <= 3'b000;
      sel_q   <= 3'b000;
      wcnt_q  <= 4'd0;
      err_q   <= 4'd0;
      timer_q <= 8'd0;
      max_q   <= 8'd0;
      hit_q   <= 1'b0;
      stb_q   <= 1'b0;
      pulse_q <= 1'b0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= obs_in;
      obs_s_q <= sync1_q;
      pat_q   <= pat_d;
      data_q  <= data_d;
      path_q  <= path_d;
      sel_q   <= sel_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      max_q   <= max_d;
      hit_q   <= hit_d;
      stb_q   <= stb_d;
      pulse_q <= pulse_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign sel        = sel_q;
  assign data_out   = data_q;
  assign stb        = stb_q;
  assign pulse      = pulse_q;
  assign ena_blocks = ena_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign max_lat    = max_q;

endmodule

// File: tb/tb_sync_test_sequencer.sv
// Scoreboard bench for sync_test_sequencer: a loopback/constant/pulse environment drives obs_in,
// a reference model predicts launched words and run results, a negedge monitor compares.
module tb_sync_test_sequencer;
  localparam int W = 8, NW = 4;
  localparam int M_LOOP = 0, M_CONST = 1, M_PULSE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1, start = 1'b0, abort = 1'b0;
  logic [2:0] path = 3'b000;
  logic [W-1:0] seed = '0, obs_in = '0;
  logic [2:0] sel;
  logic [W-1:0] data_out;
  logic stb, pulse, ena_blocks, busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] max_lat;

  always #5 clk = ~clk;

  sync_test_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .path(path), .seed(seed),
    .obs_in(obs_in), .sel(sel), .data_out(data_out), .stb(stb), .pulse(pulse),
    .ena_blocks(ena_blocks), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .max_lat(max_lat)
  );

  typedef struct { logic [3:0] err; logic [7:0] mx; logic ps; } res_t;
  logic [7:0] exp_words[$];
  res_t       exp_res[$];
  int checks = 0, failures = 0;
  int stb_cnt = 0, pulse_cnt = 0, done_cnt = 0;
  logic [7:0] prev_do = 8'h00, last_data = 8'h00;
  int mode = M_CONST, prm = 1;
  logic [7:0] cval = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pinit(input logic [7:0] s);
`ifdef SYNC_SEQ_LFSR_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [7:0] pnext(input logic [7:0] p);
`ifdef SYNC_SEQ_LFSR_EN
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    return p + 8'd1;
`endif
  endfunction

  // environment: loopback through prm flops, constant cval, or bit0 raised prm cycles after pulse
  initial begin
    logic [7:0] hist[4];
    int pcnt;
    pcnt = -1;
    for (int i = 0; i < 4; i++) hist[i] = 8'h00;
    forever begin
      @(posedge clk); #1;
      case (mode)
        M_LOOP:  obs_in = hist[prm-1];
        M_CONST: obs_in = cval;
        default: begin
          if (pulse) pcnt = 0;
          else if (pcnt >= 0) pcnt++;
          obs_in = (pcnt >= prm && pcnt < prm + 2) ? 8'h01 : 8'h00;
          if (pcnt >= prm + 2) pcnt = -1;
        end
      endcase
      if (mode != M_PULSE) pcnt = -1;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = data_out;
    end
  end

  // monitor: every data_out change while enabled is a generated pattern word
  initial begin
    logic [7:0] w;
    res_t r;
    forever begin
      @(negedge clk);
      if (ena_blocks && data_out != prev_do) begin
        if (exp_words.size() == 0) begin
          checks++; failures++;
          $display("FAIL word_extra actual=%0h expected=none", data_out);
        end else begin
          w = exp_words.pop_front();
          chk("word", 32'(data_out), 32'(w));
        end
      end
      prev_do = data_out;
      if (stb) stb_cnt++;
      if (pulse) pulse_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_res.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_extra actual=1 expected=0");
        end else begin
          r = exp_res.pop_front();
          chk("err_cnt", 32'(err_cnt), 32'(r.err));
          chk("max_lat", 32'(max_lat), 32'(r.mx));
          chk("pass", 32'(pass), 32'(r.ps));
        end
      end
    end
  end

  task automatic run_normal(input logic [2:0] p, input logic [7:0] s_in, input int m,
                            input int pr, input logic [7:0] c);
    logic [7:0] s, pv, obsv;
    res_t r;
    int lat, n, e_stb, e_pulse;
    bit to;
    mode = m; prm = pr; cval = c;
    repeat (6) @(posedge clk);
    s = s_in;
    if (p[2:1] == 2'b11) begin
      r.err = 4'hF; r.mx = 8'h00; r.ps = 1'b0;
    end else begin
      while (pnext(pinit(s)) == last_data) s++;
      pv = pinit(s);
      obsv = (m == M_LOOP) ? last_data : ((m == M_CONST) ? c : 8'h00);
      for (int i = 0; i < NW; i++) begin
        do begin
          pv = pnext(pv);
          exp_words.push_back(pv);
        end while (pv == obsv);
        if (m == M_LOOP) obsv = pv;
        last_data = pv;
      end
      to  = (m == M_CONST) && !(p == 3'b101 && c[0]);
      lat = (m == M_CONST) ? 1 : pr + 2;
      r.err = to ? 4'(NW) : 4'd0;
      r.mx  = to ? 8'd0 : 8'(lat);
      r.ps  = !to;
    end
    exp_res.push_back(r);
    e_stb   = (p == 3'b011) ? NW : 0;
    e_pulse = (p == 3'b100 || p == 3'b101) ? NW : 0;
    stb_cnt = 0; pulse_cnt = 0;
    @(posedge clk); #1 start = 1'b1; path = p; seed = s;
    @(posedge clk); #1 start = 1'b0; path = 3'($urandom); seed = 8'($urandom);
    if (p[2:1] != 2'b11) begin
      // a start while busy must not disturb the run
      repeat (2) @(posedge clk);
      #1 start = 1'b1; path = 3'($urandom_range(0, 7)); seed = 8'($urandom);
      @(posedge clk); #1 start = 1'b0;
    end
    for (n = 1; n <= 2000; n++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    if (n > 2000) begin
      checks++; failures++;
      $display("FAIL run_timeout actual=no_done expected=done path=%0d", p);
    end
    if (p[2:1] == 2'b11) chk("done_latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    chk("stb_count", 32'(stb_cnt), 32'(e_stb));
    chk("pulse_count", 32'(pulse_cnt), 32'(e_pulse));
    chk("words_left", 32'(exp_words.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] p;
    logic [7:0] s, c;
    int m, pr, d0, n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_ena", 32'(ena_blocks), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_max", 32'(max_lat), 32'd0);
    @(posedge clk); #1 rst_n = 1'b0;

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1 start = 1'b1; abort = 1'b1; path = 3'b000; seed = 8'h05;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_ena", 32'(ena_blocks), 32'd0);

    run_normal(3'b000, 8'h10, M_LOOP, 1, 8'h00);
    run_normal(3'b011, 8'($urandom), M_CONST, 0, 8'h00);
    run_normal(3'b101, 8'($urandom), M_PULSE, 5, 8'h00);
    run_normal(3'b110, 8'($urandom), M_CONST, 0, 8'h00);

    for (int r = 0; r < 12; r++) begin
      p = 3'($urandom_range(0, 7)); s = 8'($urandom); c = 8'($urandom);
      if (p == 3'b101) begin
        m  = ($urandom_range(0, 1) == 0) ? M_PULSE : M_CONST;
        pr = $urandom_range(0, 8);
      end else if (p[2:1] == 2'b11) begin
        m = M_CONST; pr = 0;
      end else begin
        m  = ($urandom_range(0, 3) == 0) ? M_CONST : M_LOOP;
        pr = $urandom_range(1, 3);
      end
      run_normal(p, s, m, pr, c);
    end

    // reset while waiting on a word
    mode = M_CONST; cval = 8'h00;
    repeat (6) @(posedge clk);
    s = 8'h20;
    while (pnext(pinit(s)) == last_data || pnext(pinit(s)) == 8'h00) s++;
    exp_words.push_back(pnext(pinit(s)));
    stb_cnt = 0;
    @(posedge clk); #1 start = 1'b1; path = 3'b011; seed = s;
    @(posedge clk); #1 start = 1'b0;
    for (n = 0; n < 20 && stb_cnt == 0; n++) @(negedge clk);
    chk("reset_run_stb", 32'(stb_cnt), 32'd1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_outs", 32'({sel, data_out, stb, pulse, ena_blocks, pass}), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    d0 = done_cnt;
    repeat (80) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt), 32'(d0));
    chk("mid_rst_words", 32'(exp_words.size()), 32'd0);
    last_data = 8'h00;

    // abort while the third word is being launched
    mode = M_LOOP; prm = 1;
    repeat (6) @(posedge clk);
    s = 8'h00;
    c = pinit(s);
    for (int i = 0; i < 3; i++) begin
      c = pnext(c);
      exp_words.push_back(c);
    end
    @(posedge clk); #1 start = 1'b1; path = 3'b000; seed = s;
    @(posedge clk); #1 start = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (exp_words.size() == 0) break;
    end
    chk("abort_words_seen", 32'(exp_words.size()), 32'd0);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outs", 32'({sel, data_out, stb, pulse, ena_blocks}), 32'd0);
    chk("abort_err_held", 32'(err_cnt), 32'd0);
    chk("abort_max_held", 32'(max_lat), 32'd3);
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("results_left", 32'(exp_res.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
